drowsy_alarm_ctrl: RTL and testbench
====================================

# drowsy_alarm_ctrl

Post-classifier decision stage sitting directly downstream of `cnn_accelerator`. It consumes the per-frame FC2 class scores streamed on the accelerator's `data_out_fc2`/`valid_out_fc2` pair and reduces each frame's scores to an argmax class. It then applies consecutive-frame hysteresis to drive the driver-drowsiness alarm. A watchdog flags a stalled classifier and forces the alarm fail-safe.

## Interface
- `N_CLASS`, 2: score beats per frame (FC2 outputs).
- `SCORE_W`, 32: signed score width.
- `CLOSED_IDX`, 0: class index meaning "eye closed".
- `CLOSE_THRESH`, 3: consecutive closed frames that raise the alarm (1..255).
- `OPEN_THRESH`, 2: consecutive open frames that clear the alarm (1..255).
- `TIMEOUT_CYC`, 400000: max cycles between score beats once armed.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `score_in` input SCORE_W: signed two's-complement class score, driven by `data_out_fc2`.
- `score_valid` input 1: beat qualifier, driven by `valid_out_fc2`.
- `class_valid` output 1: one-cycle pulse per completed frame.
- `class_id` output $clog2(N_CLASS): argmax of the last frame; held between pulses.
- `closed_run` output 8: saturating count of consecutive closed frames.
- `alarm` output 1: drowsiness warning (hysteresis state OR stall_fault).
- `stall_fault` output 1: sticky watchdog fault.
- `frame_count` output 16: completed frames, wraps at 65535→0.

## Operation
- States: IDLE (no beat of current frame yet), COLLECT (1..N_CLASS-1 beats taken). The decision is folded into the last-beat edge; there is no separate DECIDE state.
- IDLE + `score_valid`: `beat_idx`←1, `max_val`←`score_in`, `max_idx`←0, go to COLLECT.
  - If N_CLASS==1, that beat is also the last beat.
- COLLECT + `score_valid`: compare signed. Replace the running max only if `score_in` > `max_val` (strict), so ties keep the lower index. Increment `beat_idx`.
- Last beat (`beat_idx`==N_CLASS-1 with `score_valid`), same edge, registered:
  - `class_id` ← final argmax; pulse `class_valid`; `frame_count`+1; return to IDLE.
- Closed decision (argmax==CLOSED_IDX):
  - `closed_run` ← sat255(`closed_run`+1); open run ← 0.
  - If new `closed_run` ≥ CLOSE_THRESH, alarm_reg ← 1.
- Open decision:
  - `closed_run` ← 0; open run ← sat255(open run+1).
  - If new open run ≥ OPEN_THRESH, alarm_reg ← 0.
- Hysteresis only moves alarm_reg as stated above; otherwise it holds.
- Watchdog: armed by the first `score_valid` after reset.
  - Counter clears on every `score_valid` and increments otherwise.
  - When it reaches TIMEOUT_CYC: `stall_fault`←1 (sticky until `rst`); any partial frame is discarded (state→IDLE, no `class_valid`); counter holds.
- After a fault, frames are still classified and the hysteresis keeps running. `alarm` stays 1 until `rst`.
- `alarm` = alarm_reg | `stall_fault`.
- Beats are never back-pressured; the block accepts a beat every cycle.
- No arithmetic beyond signed compare; the SCORE_W score is never truncated.

## Timing
- Reset values, all held while `rst`=1: `class_valid`=0, `class_id`=0, `closed_run`=0, `alarm`=0, `stall_fault`=0, `frame_count`=0, state IDLE, watchdog disarmed, open run 0.
- Latency: last beat sampled at edge t → `class_valid`, `class_id`, `closed_run`, `frame_count`, `alarm` all update at edge t (visible in cycle t+1). `class_valid` is high exactly one cycle.
- Gaps between beats of a frame are allowed up to TIMEOUT_CYC-1 cycles.
- A `score_valid` on the same edge the counter would reach TIMEOUT_CYC wins: the beat is accepted and there is no fault.
- `rst` mid-frame discards the partial frame. The next beat is treated as index 0.
- The accelerator is reset between frames; `rst` of this block is separate, so history persists across accelerator resets.
- The last beat of frame n and the first beat of frame n+1 on consecutive cycles are both accepted.

## Test plan
- Three frames of (0: 500, 1: -200), one beat per cycle, after `rst` → `class_id`=0 each frame; `closed_run`=1,2,3; `alarm` rises on the third `class_valid` edge; `frame_count`=3.
- Alarm set, then two frames of (0: -10, 1: 40) → `closed_run`=0 after the first; `alarm` still 1 after the first, 0 after the second.
- Tie frame (0: 77, 1: 77), and a negative pair (0: -5, 1: -3) → `class_id`=0 for the tie; `class_id`=1 for the negative pair (signed compare).
- 260 consecutive closed frames → `closed_run` saturates at 255; `alarm` stays 1.
- One beat, then silence for TIMEOUT_CYC cycles (override TIMEOUT_CYC=50) → `stall_fault`=1 and `alarm`=1 at cycle 50; no `class_valid`. The next two beats give `class_valid` with `alarm` still 1.
- `rst` asserted for one cycle between beat 0 and beat 1, then a full frame (0: 1, 1: 9) → all outputs at reset values; exactly one `class_valid` with `class_id`=1 and `frame_count`=1.

Source files
------------

// File: rtl/drowsy_alarm_ctrl.sv
// Per-frame argmax over streamed class scores, consecutive-frame hysteresis
// for the drowsiness alarm, and a stall watchdog that forces the alarm on.
module drowsy_alarm_ctrl #(
    parameter int unsigned N_CLASS      = 2,
    parameter int unsigned SCORE_W      = 32,
    parameter int unsigned CLOSED_IDX   = 0,
    parameter int unsigned CLOSE_THRESH = 3,
    parameter int unsigned OPEN_THRESH  = 2,
    parameter int unsigned TIMEOUT_CYC  = 400000,
    localparam int unsigned ID_W        = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_valid,
    output logic               class_valid,
    output logic [ID_W-1:0]    class_id,
    output logic [7:0]         closed_run,
    output logic               alarm,
    output logic               stall_fault,
    output logic [15:0]        frame_count
);

    localparam int unsigned WD_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned RUN_W  = 8;
    localparam bit          SINGLE = (N_CLASS == 1);

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ID_W-1:0]           beat_idx;
    logic [ID_W-1:0]           max_idx;
    logic signed [SCORE_W-1:0] max_val;
    logic [RUN_W-1:0]          open_run;
    logic                      alarm_reg;
    logic                      wd_armed;
    logic [WD_W-1:0]           wd_cnt;

    logic                      beat_gt_c;
    logic                      last_beat_c;
    logic                      frame_done_c;
    logic                      timeout_c;
    logic                      closed_c;
    logic [ID_W-1:0]           win_idx_c;
    logic [RUN_W-1:0]          closed_inc_c;
    logic [RUN_W-1:0]          open_inc_c;
    logic                      alarm_reg_nxt_c;
    logic                      fault_nxt_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, frame completion and argmax winner
    always_comb begin
        state_nxt    = state;
        beat_gt_c    = $signed(score_in) > max_val;
        last_beat_c  = 1'b0;
        frame_done_c = 1'b0;
        win_idx_c    = '0;
        // A beat arriving on the expiry edge wins over the timeout
        timeout_c    = wd_armed && !score_valid && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
        case (state)
            S_IDLE: begin
                if (score_valid) begin
                    if (SINGLE) begin
                        frame_done_c = 1'b1;
                    end else begin
                        state_nxt = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                win_idx_c   = beat_gt_c ? beat_idx : max_idx;
                last_beat_c = (beat_idx == ID_W'(N_CLASS - 1));
                if (score_valid && last_beat_c) begin
                    frame_done_c = 1'b1;
                    state_nxt    = S_IDLE;
                end else if (timeout_c) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Hysteresis decision for the frame completing this cycle
    always_comb begin
        closed_c        = (win_idx_c == ID_W'(CLOSED_IDX));
        closed_inc_c    = (closed_run == 8'hFF) ? 8'hFF : closed_run + 8'd1;
        open_inc_c      = (open_run == 8'hFF) ? 8'hFF : open_run + 8'd1;
        alarm_reg_nxt_c = alarm_reg;
        if (frame_done_c) begin
            if (closed_c) begin
                if (closed_inc_c >= RUN_W'(CLOSE_THRESH)) begin
                    alarm_reg_nxt_c = 1'b1;
                end
            end else begin
                if (open_inc_c >= RUN_W'(OPEN_THRESH)) begin
                    alarm_reg_nxt_c = 1'b0;
                end
            end
        end
        fault_nxt_c = stall_fault | timeout_c;
    end

    // Running argmax over the beats of the current frame
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx <= '0;
            max_idx  <= '0;
            max_val  <= '0;
        end else if (score_valid) begin
            if (state == S_IDLE) begin
                max_val  <= $signed(score_in);
                max_idx  <= '0;
                beat_idx <= SINGLE ? '0 : ID_W'(1);
            end else begin
                if (beat_gt_c) begin
                    max_val <= $signed(score_in);
                    max_idx <= beat_idx;
                end
                beat_idx <= last_beat_c ? '0 : beat_idx + ID_W'(1);
            end
        end else if (timeout_c) begin
            beat_idx <= '0;
        end
    end

    // Stall watchdog: armed by the first beat, holds once expired
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_armed    <= 1'b0;
            wd_cnt      <= '0;
            stall_fault <= 1'b0;
        end else begin
            stall_fault <= fault_nxt_c;
            if (score_valid) begin
                wd_armed <= 1'b1;
                wd_cnt   <= '0;
            end else if (wd_armed && (wd_cnt != WD_W'(TIMEOUT_CYC))) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

    // Frame result, run counters and alarm
    always_ff @(posedge clk) begin
        if (rst) begin
            class_valid <= 1'b0;
            class_id    <= '0;
            closed_run  <= '0;
            open_run    <= '0;
            frame_count <= '0;
            alarm_reg   <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            class_valid <= frame_done_c;
            alarm_reg   <= alarm_reg_nxt_c;
            alarm       <= alarm_reg_nxt_c | fault_nxt_c;
            if (frame_done_c) begin
                class_id    <= win_idx_c;
                frame_count <= frame_count + 16'd1;
                if (closed_c) begin
                    closed_run <= closed_inc_c;
                    open_run   <= '0;
                end else begin
                    closed_run <= '0;
                    open_run   <= open_inc_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_drowsy_alarm_ctrl.sv
// Self-checking bench for drowsy_alarm_ctrl: directed scenarios plus a
// randomized stream checked against a frame-level behavioural model.
module tb_drowsy_alarm_ctrl;

    localparam int N_CLASS      = 2;
    localparam int CLOSED_IDX   = 0;
    localparam int CLOSE_THRESH = 3;
    localparam int OPEN_THRESH  = 2;
    localparam int TIMEOUT_CYC  = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] score_in;
    logic        score_valid;
    logic        class_valid;
    logic [0:0]  class_id;
    logic [7:0]  closed_run;
    logic        alarm;
    logic        stall_fault;
    logic [15:0] frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_beats[$];
    int m_class_valid, m_class_id, m_closed_run, m_open_run;
    int m_alarm_reg, m_fault, m_frame_count, m_armed, m_idle;

    drowsy_alarm_ctrl #(
        .N_CLASS     (N_CLASS),
        .SCORE_W     (32),
        .CLOSED_IDX  (CLOSED_IDX),
        .CLOSE_THRESH(CLOSE_THRESH),
        .OPEN_THRESH (OPEN_THRESH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .score_in   (score_in),
        .score_valid(score_valid),
        .class_valid(class_valid),
        .class_id   (class_id),
        .closed_run (closed_run),
        .alarm      (alarm),
        .stall_fault(stall_fault),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle, advance the model on the same edge, sample 1 time unit later
    task automatic step(input logic r, input logic v, input int s);
        int best;
        rst         = r;
        score_valid = v;
        score_in    = s;
        @(posedge clk);
        m_class_valid = 0;
        if (r) begin
            m_beats.delete();
            m_class_id = 0; m_closed_run = 0; m_open_run = 0; m_alarm_reg = 0;
            m_fault = 0; m_frame_count = 0; m_armed = 0; m_idle = 0;
        end else if (v) begin
            m_armed = 1;
            m_idle  = 0;
            m_beats.push_back(s);
            if (m_beats.size() == N_CLASS) begin
                best = 0;
                for (int i = 1; i < N_CLASS; i++)
                    if (m_beats[i] > m_beats[best]) best = i;
                m_beats.delete();
                m_class_valid = 1;
                m_class_id    = best;
                m_frame_count = (m_frame_count + 1) % 65536;
                if (best == CLOSED_IDX) begin
                    m_closed_run = (m_closed_run < 255) ? m_closed_run + 1 : 255;
                    m_open_run   = 0;
                    if (m_closed_run >= CLOSE_THRESH) m_alarm_reg = 1;
                end else begin
                    m_closed_run = 0;
                    m_open_run   = (m_open_run < 255) ? m_open_run + 1 : 255;
                    if (m_open_run >= OPEN_THRESH) m_alarm_reg = 0;
                end
            end
        end else if (m_armed && m_idle < TIMEOUT_CYC) begin
            m_idle++;
            if (m_idle == TIMEOUT_CYC) begin
                m_fault = 1;
                m_beats.delete();
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, int'($urandom()));
        step(1'b1, 1'b1, int'($urandom()));
        n_tests++;
        if (class_valid !== 1'b0) begin n_fail++; $display("FAIL reset_class_valid: got %0b expected 0", class_valid); end
        n_tests++;
        if (class_id !== 1'b0) begin n_fail++; $display("FAIL reset_class_id: got %0d expected 0", class_id); end
        n_tests++;
        if (closed_run !== 8'd0) begin n_fail++; $display("FAIL reset_closed_run: got %0d expected 0", closed_run); end
        n_tests++;
        if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm: got %0b expected 0", alarm); end
        n_tests++;
        if (stall_fault !== 1'b0) begin n_fail++; $display("FAIL reset_stall_fault: got %0b expected 0", stall_fault); end
        n_tests++;
        if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
    endtask

    task automatic test_closed_alarm();
        step(1'b1, 1'b0, 0);
        for (int f = 1; f <= 3; f++) begin
            step(1'b0, 1'b1, 500);
            step(1'b0, 1'b1, -200);
            n_tests++;
            if (class_valid !== 1'b1) begin n_fail++; $display("FAIL closed_valid f%0d: got %0b expected 1", f, class_valid); end
            n_tests++;
            if (class_id !== 1'b0) begin n_fail++; $display("FAIL closed_id f%0d: got %0d expected 0", f, class_id); end
            n_tests++;
            if (closed_run !== 8'(f)) begin n_fail++; $display("FAIL closed_run f%0d: got %0d expected %0d", f, closed_run, f); end
            n_tests++;
            if (alarm !== (f == 3)) begin n_fail++; $display("FAIL closed_alarm f%0d: got %0b expected %0b", f, alarm, f == 3); end
        end
        n_tests++;
        if (frame_count !== 16'd3) begin n_fail++; $display("FAIL closed_frame_count: got %0d expected 3", frame_count); end
        step(1'b0, 1'b0, 0);
        n_tests++;
        if (class_valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle: got %0b expected 0", class_valid); end
    endtask

    task automatic test_open_clear();
        for (int f = 1; f <= 2; f++) begin
            step(1'b0, 1'b1, -10);
            step(1'b0, 1'b1, 40);
            n_tests++;
            if (class_id !== 1'b1) begin n_fail++; $display("FAIL open_id f%0d: got %0d expected 1", f, class_id); end
            n_tests++;
            if (closed_run !== 8'd0) begin n_fail++; $display("FAIL open_closed_run f%0d: got %0d expected 0", f, closed_run); end
            n_tests++;
            if (alarm !== (f == 1)) begin n_fail++; $display("FAIL open_alarm f%0d: got %0b expected %0b", f, alarm, f == 1); end
        end
    endtask

    task automatic test_tie_signed();
        step(1'b0, 1'b1, 77);
        step(1'b0, 1'b1, 77);
        n_tests++;
        if (class_id !== 1'b0) begin n_fail++; $display("FAIL tie_id: got %0d expected 0", class_id); end
        step(1'b0, 1'b1, -5);
        step(1'b0, 1'b1, -3);
        n_tests++;
        if (class_id !== 1'b1) begin n_fail++; $display("FAIL signed_id: got %0d expected 1", class_id); end
        step(1'b0, 1'b1, -100000);
        step(1'b0, 1'b1, 7);
        n_tests++;
        if (class_id !== 1'b1) begin n_fail++; $display("FAIL wide_signed_id: got %0d expected 1", class_id); end
    endtask

    task automatic test_saturation();
        int exp_run;
        step(1'b1, 1'b0, 0);
        for (int f = 1; f <= 260; f++) begin
            step(1'b0, 1'b1, 9);
            step(1'b0, 1'b1, 2);
            exp_run = (f < 255) ? f : 255;
            n_tests++;
            if (closed_run !== 8'(exp_run)) begin n_fail++; $display("FAIL sat_run f%0d: got %0d expected %0d", f, closed_run, exp_run); end
        end
        n_tests++;
        if (alarm !== 1'b1) begin n_fail++; $display("FAIL sat_alarm: got %0b expected 1", alarm); end
        n_tests++;
        if (frame_count !== 16'd260) begin n_fail++; $display("FAIL sat_frame_count: got %0d expected 260", frame_count); end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 11);
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            step(1'b0, 1'b0, 0);
            n_tests++;
            if (stall_fault !== (k == TIMEOUT_CYC)) begin n_fail++; $display("FAIL stall_fault k%0d: got %0b expected %0b", k, stall_fault, k == TIMEOUT_CYC); end
            n_tests++;
            if (class_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_valid k%0d: got %0b expected 0", k, class_valid); end
        end
        n_tests++;
        if (alarm !== 1'b1) begin n_fail++; $display("FAIL stall_alarm: got %0b expected 1", alarm); end
        step(1'b0, 1'b1, 3);
        step(1'b0, 1'b1, 8);
        n_tests++;
        if (class_valid !== 1'b1) begin n_fail++; $display("FAIL post_stall_valid: got %0b expected 1", class_valid); end
        n_tests++;
        if (class_id !== 1'b1) begin n_fail++; $display("FAIL post_stall_id: got %0d expected 1", class_id); end
        n_tests++;
        if (alarm !== 1'b1) begin n_fail++; $display("FAIL post_stall_alarm: got %0b expected 1", alarm); end
        n_tests++;
        if (frame_count !== 16'd1) begin n_fail++; $display("FAIL post_stall_count: got %0d expected 1", frame_count); end
    endtask

    task automatic test_watchdog_edge();
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 20);
        for (int k = 1; k < TIMEOUT_CYC; k++) step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 30);
        n_tests++;
        if (stall_fault !== 1'b0) begin n_fail++; $display("FAIL edge_fault: got %0b expected 0", stall_fault); end
        n_tests++;
        if (class_valid !== 1'b1) begin n_fail++; $display("FAIL edge_valid: got %0b expected 1", class_valid); end
        n_tests++;
        if (class_id !== 1'b1) begin n_fail++; $display("FAIL edge_id: got %0d expected 1", class_id); end
    endtask

    task automatic test_rst_midframe();
        int pulses;
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 50);
        step(1'b1, 1'b0, 0);
        n_tests++;
        if (class_valid !== 1'b0 || class_id !== 1'b0 || closed_run !== 8'd0 || alarm !== 1'b0 ||
            stall_fault !== 1'b0 || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got valid=%0b id=%0d run=%0d alarm=%0b fault=%0b count=%0d expected all 0",
                     class_valid, class_id, closed_run, alarm, stall_fault, frame_count);
        end
        pulses = 0;
        step(1'b0, 1'b1, 1);
        pulses += int'(class_valid);
        step(1'b0, 1'b1, 9);
        pulses += int'(class_valid);
        n_tests++;
        if (class_id !== 1'b1) begin n_fail++; $display("FAIL midrst_id: got %0d expected 1", class_id); end
        n_tests++;
        if (frame_count !== 16'd1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", frame_count); end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 0);
            pulses += int'(class_valid);
        end
        n_tests++;
        if (pulses != 1) begin n_fail++; $display("FAIL midrst_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_back_to_back_random();
        int gap;
        int s;
        step(1'b1, 1'b0, 0);
        for (int c = 0; c < 1500; c++) begin
            gap = 0;
            if ($urandom_range(0, 99) < 2) gap = $urandom_range(40, 56);
            if ($urandom_range(0, 3) == 0) s = int'($urandom());
            else s = int'($urandom_range(0, 8)) - 4;
            if (gap > 0) begin
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 0);
            end else begin
                step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), s);
            end
            n_tests++;
            if (class_valid !== 1'(m_class_valid) || class_id !== 1'(m_class_id) ||
                closed_run !== 8'(m_closed_run) || frame_count !== 16'(m_frame_count) ||
                stall_fault !== 1'(m_fault) || alarm !== 1'(m_alarm_reg | m_fault)) begin
                n_fail++;
                $display("FAIL random c%0d: got valid=%0b id=%0d run=%0d count=%0d fault=%0b alarm=%0b expected valid=%0d id=%0d run=%0d count=%0d fault=%0d alarm=%0d",
                         c, class_valid, class_id, closed_run, frame_count, stall_fault, alarm,
                         m_class_valid, m_class_id, m_closed_run, m_frame_count, m_fault, m_alarm_reg | m_fault);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        score_valid = 1'b0;
        score_in    = '0;
        test_reset();
        test_closed_alarm();
        test_open_clear();
        test_tie_signed();
        test_saturation();
        test_stall();
        test_watchdog_edge();
        test_rst_midframe();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
